// File: rtl/cursor_scan_ctrl_pkg.sv
// Shared definitions for the LED-matrix cursor sequencer.
// Contents: default matrix geometry, confirm FSM state encoding and the
// per-button rising-edge event bundle.
package cursor_scan_ctrl_pkg;

    localparam int unsigned COLS_DEF = 5;
    localparam int unsigned ROWS_DEF = 7;

    // Confirm sequence: IDLE -> SETTLE (selector resolves) -> LATCH (capture) -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LATCH  = 2'd2
    } state_e;

    // One-cycle rising-edge events, one bit per button
    typedef struct packed {
        logic ok;
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_ev_t;

endpackage

// File: rtl/cursor_scan_ctrl_if.sv
// Button / selector / cursor bundle between the sequencer and its surroundings.
// slave  : the cursor_scan_ctrl side (takes buttons and dmx4_sel, drives cursor and select).
// master : the environment side (button front end and coordinate selector).
interface cursor_scan_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_ok;
    logic [1:0] dmx4_sel;
    logic [2:0] mdc;
    logic [2:0] mdl;
    logic [1:0] sel_out;
    logic       sel_valid;
    logic       busy;

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_ok, dmx4_sel,
        output mdc, mdl, sel_out, sel_valid, busy
    );

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_ok, dmx4_sel,
        input  mdc, mdl, sel_out, sel_valid, busy
    );
endinterface

// File: rtl/cursor_scan_ctrl_edge.sv
// Rising-edge detector for one synchronized button level.
// Ports: clk, rst (sync, active-high), btn_i (level), pulse_o (registered
// one-cycle pulse on each 0->1 sample; a held level never repeats).
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);
    logic hist_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= btn_i;
            pulse_q <= btn_i & ~hist_q;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/cursor_scan_ctrl.sv
// LED-matrix cursor sequencer.
// Holds the cursor (mdc column, mdl line), moves it with wrap on button edges,
// runs the confirm sequence that latches the external selector's dmx4_sel, and
// scans the matrix columns drawing a blinking cursor dot.
// Ports: clk, rst (sync, active-high), bus (cursor_scan_ctrl_if.slave),
//        col_n (active-low one-hot column), row (active-high line drive).
module cursor_scan_ctrl
    import cursor_scan_ctrl_pkg::*;
#(
    parameter int unsigned COLS         = COLS_DEF,
    parameter int unsigned ROWS         = ROWS_DEF,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cursor_scan_ctrl_if.slave    bus,
    output logic [COLS-1:0]      col_n,
    output logic [ROWS-1:0]      row
);
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    btn_ev_t        ev;
    state_e         state_q;
    logic [2:0]     mdc_q, mdc_d, mdl_q, mdl_d;
    logic [1:0]     sel_out_q;
    logic           sel_valid_q, busy_q;
    logic [PW-1:0]  presc_q, presc_d;
    logic [2:0]     col_idx_q, col_idx_d;
    logic [FW-1:0]  frame_q, frame_d;
    logic           blink_q, blink_d;
    logic [COLS-1:0] col_n_q, col_n_d;
    logic [ROWS-1:0] row_q, row_d;
    logic           presc_tc, col_wrap;

    btn_edge_detect u_ok    (.clk(clk), .rst(rst), .btn_i(bus.btn_ok),    .pulse_o(ev.ok));
    btn_edge_detect u_up    (.clk(clk), .rst(rst), .btn_i(bus.btn_up),    .pulse_o(ev.up));
    btn_edge_detect u_down  (.clk(clk), .rst(rst), .btn_i(bus.btn_down),  .pulse_o(ev.down));
    btn_edge_detect u_left  (.clk(clk), .rst(rst), .btn_i(bus.btn_left),  .pulse_o(ev.left));
    btn_edge_detect u_right (.clk(clk), .rst(rst), .btn_i(bus.btn_right), .pulse_o(ev.right));

    // Cursor move: only in IDLE, one action per cycle, ok > up > down > left > right
    always_comb begin
        mdc_d = mdc_q;
        mdl_d = mdl_q;
        if (state_q == ST_IDLE && !ev.ok) begin
            if (ev.up)
                mdl_d = (mdl_q == 3'd0) ? 3'(ROWS - 1) : mdl_q - 3'd1;
            else if (ev.down)
                mdl_d = (mdl_q == 3'(ROWS - 1)) ? 3'd0 : mdl_q + 3'd1;
            else if (ev.left)
                mdc_d = (mdc_q == 3'd0) ? 3'(COLS - 1) : mdc_q - 3'd1;
            else if (ev.right)
                mdc_d = (mdc_q == 3'(COLS - 1)) ? 3'd0 : mdc_q + 3'd1;
        end
    end

    // Scan prescaler, column index, frame counter and blink phase
    always_comb begin
        presc_tc  = (presc_q == PW'(SCAN_DIV - 1));
        col_wrap  = presc_tc && (col_idx_q == 3'(COLS - 1));
        presc_d   = presc_tc ? '0 : presc_q + PW'(1);
        col_idx_d = col_idx_q;
        frame_d   = frame_q;
        blink_d   = blink_q;
        if (presc_tc)
            col_idx_d = col_wrap ? 3'd0 : col_idx_q + 3'd1;
        if (col_wrap) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
        // Drives are computed from next state so the registered outputs track the current state
        col_n_d = ~(COLS'(1) << col_idx_d);
        row_d   = (col_idx_d == mdc_d && blink_d) ? (ROWS'(1) << mdl_d) : '0;
    end

    // Confirm FSM and cursor registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mdc_q       <= 3'd0;
            mdl_q       <= 3'd0;
            sel_out_q   <= 2'd0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mdc_q       <= mdc_d;
            mdl_q       <= mdl_d;
            sel_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ev.ok) begin
                        state_q <= ST_SETTLE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Cursor has been stable for a full cycle: capture the selector result
                    state_q     <= ST_LATCH;
                    sel_out_q   <= bus.dmx4_sel;
                    sel_valid_q <= 1'b1;
                end
                ST_LATCH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Column scan and blink registers
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            col_idx_q <= 3'd0;
            frame_q   <= '0;
            blink_q   <= 1'b1;
            col_n_q   <= ~COLS'(1);
            row_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            col_idx_q <= col_idx_d;
            frame_q   <= frame_d;
            blink_q   <= blink_d;
            col_n_q   <= col_n_d;
            row_q     <= row_d;
        end
    end

    assign bus.mdc       = mdc_q;
    assign bus.mdl       = mdl_q;
    assign bus.sel_out   = sel_out_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.busy      = busy_q;
    assign col_n         = col_n_q;
    assign row           = row_q;
endmodule
